simon_ctrl: RTL and testbench

- Iterative SIMON block-cipher engine with control FSM.
- Default configuration is SIMON32/64.
- Captures a master key, expands it into a round-key store, then encrypts or decrypts one block at one round per clock.
- Sits between the host interface and the result register; raises load/done handshakes and passes an info/count byte through.

---
 rtl/simon_ctrl.sv | 177 +++++++++++++++++
 tb/tb_simon_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_ctrl.sv
// simon_ctrl: iterative SIMON block-cipher engine with control FSM (default SIMON32/64).
// A master key is captured and expanded into a round-key store, one key per clock.
// After that, a block is encrypted or decrypted at one round per clock.
// Ports:
//   clk       rising-edge clock
//   nR        synchronous reset, active-high
//   newDATA   start a block on its 0->1 transition (needs valid round keys)
//   newKEY    load and expand KEY on its 0->1 transition
//   readDATA  host acknowledge of the result
//   infoIN    command byte: bit7 1=encrypt 0=decrypt, bits6:0 tag
//   countIN   round override, 0 or >T selects T rounds
//   inDATA    block {x, y}
//   KEY       master key, KEY[0] = k0 in the low word
//   loadKEY   one-cycle pulse when the key is captured
//   loadDATA  one-cycle pulse when the block is captured
//   doneKEY   round keys valid
//   doneDATA  outDATA valid
//   infoOUT   latched command byte with bit1=doneDATA, bit0=doneKEY
//   countOUT  current round index
//   outDATA   result block {x, y}
module simon_ctrl #(
    parameter int unsigned N = 16,
    parameter int unsigned M = 4,
    parameter int unsigned T = 32,
    // z0 constant sequence, bit j = z0[j]
    parameter logic [61:0] Z = 62'h19C3522FB386A45F
) (
    input  logic             clk,
    input  logic             nR,
    input  logic             newDATA,
    input  logic             newKEY,
    input  logic             readDATA,
    input  logic [7:0]       infoIN,
    input  logic [7:0]       countIN,
    input  logic [2*N-1:0]   inDATA,
    input  logic [M*N-1:0]   KEY,
    output logic             loadKEY,
    output logic             loadDATA,
    output logic             doneKEY,
    output logic             doneDATA,
    output logic [7:0]       infoOUT,
    output logic [7:0]       countOUT,
    output logic [2*N-1:0]   outDATA
);

    localparam int unsigned IW = $clog2(T);
    localparam logic [7:0]  T8 = 8'(T);

    typedef enum logic [2:0] {IDLE, KEXP, READY, RUN, DONE} state_t;

    state_t        state;
    logic [N-1:0]  rk [T];
    logic [IW-1:0] kIdx;
    logic [N-1:0]  xR, yR;
    logic [5:0]    infoTag;
    logic [7:0]    rounds;
    logic          keyPrev, dataPrev;
    logic          keyRise, dataRise;
    logic [N-1:0]  kTmp, kNext, rkSel, xNext, yNext;
    logic [5:0]    zIdx;
    logic [IW-1:0] rIdx;
    logic          lastRound;
    logic          unusedInfoBits;

    function automatic logic [N-1:0] rol(input logic [N-1:0] v, input int unsigned s);
        return (v << s) | (v >> (N - s));
    endfunction

    function automatic logic [N-1:0] fRound(input logic [N-1:0] v);
        return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
    endfunction

    assign keyRise  = newKEY & ~keyPrev;
    assign dataRise = newDATA & ~dataPrev;

    // Bits 1:0 of the command byte are replaced by the done flags.
    assign unusedInfoBits = ^infoIN[1:0];
    assign infoOUT = {infoTag, doneDATA, doneKEY};

    // Next round key rk[kIdx] from the previously expanded words
    always_comb begin
        kTmp = rol(rk[kIdx - IW'(1)], N - 3);
        if (M == 4) begin
            kTmp = kTmp ^ rk[kIdx - IW'(3)];
        end
        kTmp  = kTmp ^ rol(kTmp, N - 1);
        zIdx  = 6'((32'(kIdx) - M) % 62);
        kNext = ~rk[kIdx - IW'(M)] ^ kTmp ^ N'(Z[zIdx]) ^ N'(3);
    end

    // One cipher round; decryption walks the key schedule backwards
    always_comb begin
        rIdx  = infoTag[5] ? IW'(countOUT) : IW'(rounds - 8'd1 - countOUT);
        rkSel = rk[rIdx];
        if (infoTag[5]) begin
            xNext = yR ^ fRound(xR) ^ rkSel;
            yNext = xR;
        end else begin
            xNext = yR;
            yNext = xR ^ fRound(yR) ^ rkSel;
        end
        lastRound = (countOUT == rounds - 8'd1);
    end

    // Control FSM with registered outputs; the key store itself is not reset
    always_ff @(posedge clk) begin
        if (nR) begin
            state    <= IDLE;
            keyPrev  <= 1'b0;
            dataPrev <= 1'b0;
            loadKEY  <= 1'b0;
            loadDATA <= 1'b0;
            doneKEY  <= 1'b0;
            doneDATA <= 1'b0;
            countOUT <= 8'd0;
            outDATA  <= '0;
            infoTag  <= 6'd0;
            rounds   <= 8'd0;
            kIdx     <= '0;
            xR       <= '0;
            yR       <= '0;
        end else begin
            keyPrev  <= newKEY;
            dataPrev <= newDATA;
            loadKEY  <= 1'b0;
            loadDATA <= 1'b0;
            case (state)
                IDLE, READY, DONE: begin
                    if (keyRise) begin
                        for (int k = 0; k < int'(M); k++) begin
                            rk[k] <= KEY[k*N +: N];
                        end
                        loadKEY  <= 1'b1;
                        doneKEY  <= 1'b0;
                        doneDATA <= 1'b0;
                        kIdx     <= IW'(M);
                        state    <= KEXP;
                    end else if (dataRise && doneKEY) begin
                        // A capture also serves as the acknowledge of a pending result
                        xR       <= inDATA[2*N-1:N];
                        yR       <= inDATA[N-1:0];
                        infoTag  <= infoIN[7:2];
                        rounds   <= (countIN != 8'd0 && countIN <= T8) ? countIN : T8;
                        loadDATA <= 1'b1;
                        doneDATA <= 1'b0;
                        countOUT <= 8'd0;
                        state    <= RUN;
                    end else if (state == DONE && readDATA) begin
                        doneDATA <= 1'b0;
                        state    <= READY;
                    end
                end
                KEXP: begin
                    rk[kIdx] <= kNext;
                    if (kIdx == IW'(T - 1)) begin
                        doneKEY <= 1'b1;
                        state   <= READY;
                    end else begin
                        kIdx <= kIdx + IW'(1);
                    end
                end
                RUN: begin
                    xR       <= xNext;
                    yR       <= yNext;
                    countOUT <= countOUT + 8'd1;
                    if (lastRound) begin
                        outDATA  <= {xNext, yNext};
                        doneDATA <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simon_ctrl.sv
// tb_simon_ctrl: known-answer table, multi-cycle corner sequences and randomized
// blocks checked against a SIMON32/64 reference model.
module tb_simon_ctrl;

    logic        clk = 1'b0;
    logic        nR, newDATA, newKEY, readDATA;
    logic [7:0]  infoIN, countIN;
    logic [31:0] inDATA;
    logic [63:0] KEY;
    logic        loadKEY, loadDATA, doneKEY, doneDATA;
    logic [7:0]  infoOUT, countOUT;
    logic [31:0] outDATA;

    int nChecks = 0;
    int nFail   = 0;

    localparam logic [63:0] KAT_KEY = 64'h1918_1110_0908_0100;

    // SIMON z0 sequence written out bit by bit, z0[0] first
    string zStr = "11111010001001010110000111001101111101000100101011000011100110";
    logic [15:0] mrk [32];

    typedef struct {
        logic [7:0]  info;
        logic [7:0]  cnt;
        logic [31:0] din;
        logic [31:0] dout;
        int          lat;
    } vec_t;
    vec_t vecs [6];

    simon_ctrl dut (
        .clk(clk), .nR(nR), .newDATA(newDATA), .newKEY(newKEY), .readDATA(readDATA),
        .infoIN(infoIN), .countIN(countIN), .inDATA(inDATA), .KEY(KEY),
        .loadKEY(loadKEY), .loadDATA(loadDATA), .doneKEY(doneKEY), .doneDATA(doneDATA),
        .infoOUT(infoOUT), .countOUT(countOUT), .outDATA(outDATA)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] rol16(input logic [15:0] v, input int s);
        return (v << s) | (v >> (16 - s));
    endfunction

    function automatic logic [15:0] fm(input logic [15:0] v);
        return (rol16(v, 1) & rol16(v, 8)) ^ rol16(v, 2);
    endfunction

    // Reference key schedule: c = 2^16-4, k[i] = c ^ z0[i-4] ^ k[i-4] ^ (I ^ S^-1)(S^-3 k[i-1] ^ k[i-3])
    task automatic modelKey(input logic [63:0] key);
        logic [15:0] t;
        for (int i = 0; i < 4; i++) mrk[i] = key[16*i +: 16];
        for (int i = 4; i < 32; i++) begin
            t = rol16(mrk[i-1], 13) ^ mrk[i-3];
            t = t ^ rol16(t, 15);
            mrk[i] = 16'hFFFC ^ mrk[i-4] ^ t ^ ((zStr[i-4] == "1") ? 16'd1 : 16'd0);
        end
    endtask

    function automatic int modelRounds(input logic [7:0] cnt);
        return (cnt >= 1 && cnt <= 32) ? int'(cnt) : 32;
    endfunction

    function automatic logic [31:0] modelCrypt(input logic enc, input int r, input logic [31:0] din);
        logic [15:0] x, y;
        x = din[31:16];
        y = din[15:0];
        if (enc) begin
            for (int i = 0; i < r; i++) {x, y} = {y ^ fm(x) ^ mrk[i], x};
        end else begin
            for (int i = r - 1; i >= 0; i--) {x, y} = {y, x ^ fm(y) ^ mrk[i]};
        end
        return {x, y};
    endfunction

    task automatic loadKey(input string nm, input logic [63:0] key);
        int c;
        KEY = key;
        newKEY = 1'b1;
        tick();
        check({nm, " loadKEY pulse"}, loadKEY, 1);
        check({nm, " doneKEY cleared"}, doneKEY, 0);
        tick();
        check({nm, " loadKEY single"}, loadKEY, 0);
        newKEY = 1'b0;
        c = 1;
        while (!doneKEY && c < 200) begin
            tick();
            c++;
        end
        check({nm, " doneKEY latency"}, c, 28);
        check({nm, " infoOUT[0]"}, infoOUT[0], 1);
        modelKey(key);
    endtask

    task automatic runBlock(input string nm, input logic [7:0] info, input logic [7:0] cnt,
                            input logic [31:0] din, input logic [31:0] expOut, input int expLat);
        int c;
        infoIN = info;
        countIN = cnt;
        inDATA = din;
        newDATA = 1'b1;
        tick();
        check({nm, " loadDATA pulse"}, loadDATA, 1);
        check({nm, " doneDATA low at load"}, doneDATA, 0);
        tick();
        check({nm, " loadDATA single"}, loadDATA, 0);
        newDATA = 1'b0;
        c = 1;
        while (!doneDATA && c < 300) begin
            tick();
            c++;
        end
        check({nm, " doneDATA latency"}, c, expLat);
        check({nm, " outDATA"}, outDATA, expOut);
        check({nm, " infoOUT"}, infoOUT, {info[7:2], 2'b11});
        check({nm, " countOUT"}, countOUT, expLat);
        readDATA = 1'b1;
        tick();
        check({nm, " ack clears doneDATA"}, doneDATA, 0);
        readDATA = 1'b0;
    endtask

    initial begin
        int c;
        logic [7:0]  rInfo, rCnt;
        logic [31:0] rDin;
        int          rR;

        vecs[0] = '{8'hD0, 8'd0,   32'h6565_6877, 32'hC69B_E9BB, 32};
        vecs[1] = '{8'h50, 8'd0,   32'hC69B_E9BB, 32'h6565_6877, 32};
        vecs[2] = '{8'hD0, 8'd1,   32'h0000_0000, 32'h0100_0000, 1};
        vecs[3] = '{8'h50, 8'd1,   32'h0100_0000, 32'h0000_0000, 1};
        vecs[4] = '{8'h81, 8'd200, 32'h6565_6877, 32'hC69B_E9BB, 32};
        vecs[5] = '{8'hA5, 8'd32,  32'h6565_6877, 32'hC69B_E9BB, 32};

        nR = 1'b1; newDATA = 1'b0; newKEY = 1'b0; readDATA = 1'b0;
        infoIN = 8'd0; countIN = 8'd0; inDATA = 32'd0; KEY = 64'd0;
        tick();
        tick();
        check("reset loadKEY", loadKEY, 0);
        check("reset loadDATA", loadDATA, 0);
        check("reset doneKEY", doneKEY, 0);
        check("reset doneDATA", doneDATA, 0);
        check("reset infoOUT", infoOUT, 0);
        check("reset countOUT", countOUT, 0);
        check("reset outDATA", outDATA, 0);
        nR = 1'b0;

        // Block request without round keys is ignored
        inDATA = 32'h6565_6877;
        newDATA = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no key loadDATA", loadDATA, 0);
            check("no key doneDATA", doneDATA, 0);
        end
        newDATA = 1'b0;
        tick();

        loadKey("kat key", KAT_KEY);

        for (int i = 0; i < 6; i++) begin
            runBlock($sformatf("vec%0d", i), vecs[i].info, vecs[i].cnt, vecs[i].din,
                     vecs[i].dout, vecs[i].lat);
        end

        // newKEY rise during RUN has no effect
        infoIN = 8'hD0; countIN = 8'd0; inDATA = 32'h6565_6877; newDATA = 1'b1;
        tick();
        check("run-key loadDATA", loadDATA, 1);
        newDATA = 1'b0;
        c = 0;
        repeat (3) begin tick(); c++; end
        newKEY = 1'b1;
        tick(); c++;
        check("run-key no loadKEY", loadKEY, 0);
        newKEY = 1'b0;
        while (!doneDATA && c < 300) begin tick(); c++; end
        check("run-key latency", c, 32);
        check("run-key outDATA", outDATA, 32'hC69B_E9BB);
        check("run-key doneKEY kept", doneKEY, 1);

        // Acknowledge and new block on the same edge: the capture wins
        infoIN = 8'h50; inDATA = 32'hC69B_E9BB; readDATA = 1'b1; newDATA = 1'b1;
        tick();
        check("ack+new loadDATA", loadDATA, 1);
        check("ack+new doneDATA cleared", doneDATA, 0);
        readDATA = 1'b0; newDATA = 1'b0;
        c = 0;
        while (!doneDATA && c < 300) begin tick(); c++; end
        check("ack+new latency", c, 32);
        check("ack+new outDATA", outDATA, 32'h6565_6877);
        check("ack+new infoOUT", infoOUT, 8'h53);
        readDATA = 1'b1;
        tick();
        readDATA = 1'b0;

        // Reset in the middle of RUN
        infoIN = 8'hD0; countIN = 8'd0; inDATA = 32'h1234_5678; newDATA = 1'b1;
        tick();
        newDATA = 1'b0;
        repeat (5) tick();
        check("abort countOUT mid-run", countOUT, 5);
        nR = 1'b1;
        tick();
        nR = 1'b0;
        check("abort doneKEY", doneKEY, 0);
        check("abort doneDATA", doneDATA, 0);
        check("abort loadDATA", loadDATA, 0);
        check("abort infoOUT", infoOUT, 0);
        check("abort countOUT", countOUT, 0);
        check("abort outDATA", outDATA, 0);
        newDATA = 1'b1;
        tick();
        check("abort needs key", loadDATA, 0);
        tick();
        check("abort stays idle", doneDATA, 0);
        check("abort countOUT idle", countOUT, 0);
        newDATA = 1'b0;
        tick();

        loadKey("reload key", KAT_KEY);
        runBlock("after reload", 8'hD0, 8'd0, 32'h6565_6877, 32'hC69B_E9BB, 32);

        // Randomized keys, modes, round counts and blocks
        for (int i = 0; i < 20; i++) begin
            if (i % 5 == 0) loadKey($sformatf("rnd key%0d", i), {$urandom, $urandom});
            rInfo = 8'($urandom);
            rCnt  = 8'($urandom_range(0, 40));
            rDin  = $urandom;
            rR    = modelRounds(rCnt);
            runBlock($sformatf("rnd%0d", i), rInfo, rCnt, rDin,
                     modelCrypt(rInfo[7], rR, rDin), rR);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
